// File: rtl/pattern_pkg.sv
`default_nettype none
// ==========================================================================
// pattern_pkg : mode encodings, colour-bar lookup and channel levels
// Rev 1.0
// ==========================================================================
package pattern_pkg;

  typedef enum logic [2:0] {
    MODE_BARS  = 3'd0,
    MODE_CHECK = 3'd1,
    MODE_GRAD  = 3'd2,
    MODE_BOX   = 3'd3,
    MODE_FLASH = 3'd4
  } mode_e;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } bar_rgb_t;

  // Bar index 0..7 maps to white, yellow, cyan, green, magenta, red, blue, black.
  function automatic bar_rgb_t bar_lookup(input logic [2:0] idx);
    bar_rgb_t c;
    c.r = ~idx[1];
    c.g = ~idx[2];
    c.b = ~idx[0];
    return c;
  endfunction

  // Levels are returned 32 bits wide; callers cast down to their channel width.
  function automatic logic [31:0] chan_level(input int color_w, input logic on);
    return on ? ((32'd1 << color_w) - 32'd1) : 32'd0;
  endfunction

  // 0x40 on an 8-bit channel, i.e. one quarter of full scale.
  function automatic logic [31:0] dark_level(input int color_w);
    return 32'd1 << (color_w - 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pattern_box_mover.sv
`default_nettype none
// ==========================================================================
// pattern_box_mover : bouncing-box position and direction, one step per frame
// Rev 1.0
// ==========================================================================
module pattern_box_mover #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int CW       = 12,
  parameter int BOX_SIZE = 32
) (
  input  logic          i_pixclk,
  input  logic          reset,
  input  logic          i_step,
  output logic [CW-1:0] o_box_x_next,
  output logic [CW-1:0] o_box_y_next
);

  for (genvar a = 0; a < 2; a++) begin : g_axis
    localparam int C_LIMIT = (a == 0) ? (H_ACTIVE - BOX_SIZE) : (V_ACTIVE - BOX_SIZE);

    logic [CW-1:0] r_pos;
    logic [CW-1:0] w_pos_next;
    logic          r_neg;
    logic          w_neg_next;

    // At either wall the direction flips and the box steps back instead of through.
    always_comb begin
      w_pos_next = r_pos;
      w_neg_next = r_neg;
      if (i_step) begin
        if (!r_neg) begin
          if (r_pos >= CW'(C_LIMIT)) begin
            w_neg_next = 1'b1;
            w_pos_next = r_pos - CW'(1);
          end else begin
            w_pos_next = r_pos + CW'(1);
          end
        end else begin
          if (r_pos == '0) begin
            w_neg_next = 1'b0;
            w_pos_next = r_pos + CW'(1);
          end else begin
            w_pos_next = r_pos - CW'(1);
          end
        end
      end
    end

    always_ff @(posedge i_pixclk) begin
      if (reset) begin
        r_pos <= '0;
        r_neg <= 1'b0;
      end else begin
        r_pos <= w_pos_next;
        r_neg <= w_neg_next;
      end
    end
  end

  assign o_box_x_next = g_axis[0].w_pos_next;
  assign o_box_y_next = g_axis[1].w_pos_next;

endmodule
`default_nettype wire

// File: rtl/pattern_gen.sv
`default_nettype none
// ==========================================================================
// pattern_gen : multi-mode HDMI test-pattern source driven by timing strobes
// Rev 1.0
// ==========================================================================
module pattern_gen
  import pattern_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int CW         = 12,
  parameter int COLOR_W    = 8,
  parameter int CHECK_LOG2 = 5,
  parameter int BOX_SIZE   = 32
) (
  input  logic               i_pixclk,
  input  logic               reset,
  input  logic [2:0]         i_mode,
  input  logic               i_rd,
  input  logic               i_newline,
  input  logic               i_newframe,
  output logic [COLOR_W-1:0] o_red,
  output logic [COLOR_W-1:0] o_grn,
  output logic [COLOR_W-1:0] o_blu,
  output logic [CW-1:0]      o_hcount,
  output logic [CW-1:0]      o_vcount,
  output logic [7:0]         o_frame,
  output logic [2:0]         o_mode,
  output logic               o_overrun
);

  localparam int               C_BAR_LEN = H_ACTIVE / 8;
  localparam int               C_BAR_W   = $clog2(C_BAR_LEN);
  localparam logic [COLOR_W-1:0] C_WHITE = COLOR_W'(chan_level(COLOR_W, 1'b1));
  localparam logic [COLOR_W-1:0] C_BLACK = COLOR_W'(chan_level(COLOR_W, 1'b0));
  localparam logic [COLOR_W-1:0] C_DARK  = COLOR_W'(dark_level(COLOR_W));
  localparam logic [CW:0]        C_BOX   = (CW+1)'(BOX_SIZE);

  logic [CW-1:0]      r_hcount, w_hcount_next;
  logic [CW-1:0]      r_vcount, w_vcount_next;
  logic [7:0]         r_frame,  w_frame_next;
  logic [2:0]         r_mode,   w_mode_next;
  logic               r_overrun, w_overrun_next;
  logic [C_BAR_W-1:0] r_bar_cnt, w_bar_cnt_next;
  logic [2:0]         r_bar_idx, w_bar_idx_next;
  logic [COLOR_W-1:0] r_red, r_grn, r_blu;
  logic [COLOR_W-1:0] w_red, w_grn, w_blu;
  logic [CW-1:0]      w_box_x, w_box_y;
  logic               w_in_box;
  bar_rgb_t           w_bar;

  pattern_box_mover #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .CW       (CW),
    .BOX_SIZE (BOX_SIZE)
  ) u_box (
    .i_pixclk     (i_pixclk),
    .reset        (reset),
    .i_step       (i_newframe),
    .o_box_x_next (w_box_x),
    .o_box_y_next (w_box_y)
  );

  always_comb begin
    w_hcount_next  = r_hcount;
    w_vcount_next  = r_vcount;
    w_frame_next   = r_frame;
    w_mode_next    = r_mode;
    w_overrun_next = r_overrun;
    w_bar_cnt_next = r_bar_cnt;
    w_bar_idx_next = r_bar_idx;
    if (i_newline) begin
      w_hcount_next  = '0;
      w_bar_cnt_next = '0;
      w_bar_idx_next = '0;
      if (r_vcount < CW'(V_ACTIVE)) w_vcount_next = r_vcount + CW'(1);
    end else if (i_rd) begin
      if (r_hcount >= CW'(H_ACTIVE)) begin
        w_overrun_next = 1'b1;
      end else begin
        w_hcount_next = r_hcount + CW'(1);
        if (r_bar_cnt == C_BAR_W'(C_BAR_LEN - 1)) begin
          w_bar_cnt_next = '0;
          w_bar_idx_next = r_bar_idx + 3'd1;
        end else begin
          w_bar_cnt_next = r_bar_cnt + C_BAR_W'(1);
        end
      end
    end
    if (i_newframe) begin
      w_vcount_next = '0;
      w_frame_next  = r_frame + 8'd1;
      w_mode_next   = i_mode;
    end
  end

  assign w_in_box = ({1'b0, w_hcount_next} >= {1'b0, w_box_x}) &&
                    ({1'b0, w_hcount_next} <  {1'b0, w_box_x} + C_BOX) &&
                    ({1'b0, w_vcount_next} >= {1'b0, w_box_y}) &&
                    ({1'b0, w_vcount_next} <  {1'b0, w_box_y} + C_BOX);

  // Pixel colour is derived from next-state values so the registered RGB has no lag.
  always_comb begin
    w_red = C_BLACK;
    w_grn = C_BLACK;
    w_blu = C_BLACK;
    w_bar = bar_lookup(w_bar_idx_next);
    if ((w_hcount_next < CW'(H_ACTIVE)) && (w_vcount_next < CW'(V_ACTIVE))) begin
      case (w_mode_next)
        MODE_BARS: begin
          w_red = w_bar.r ? C_WHITE : C_BLACK;
          w_grn = w_bar.g ? C_WHITE : C_BLACK;
          w_blu = w_bar.b ? C_WHITE : C_BLACK;
        end
        MODE_CHECK: begin
          if (w_hcount_next[CHECK_LOG2] ^ w_vcount_next[CHECK_LOG2]) begin
            w_red = C_WHITE;
            w_grn = C_WHITE;
            w_blu = C_WHITE;
          end
        end
        MODE_GRAD: begin
          w_red = w_hcount_next[COLOR_W-1:0];
          w_grn = w_vcount_next[COLOR_W-1:0];
          w_blu = COLOR_W'(w_frame_next);
        end
        MODE_BOX: begin
          if (w_in_box) w_grn = C_WHITE;
          else          w_blu = C_DARK;
        end
        MODE_FLASH: begin
          if (w_frame_next[5]) begin
            w_red = C_WHITE;
            w_grn = C_WHITE;
            w_blu = C_WHITE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_pixclk) begin
    if (reset) begin
      r_hcount  <= '0;
      r_vcount  <= '0;
      r_frame   <= '0;
      r_mode    <= '0;
      r_overrun <= 1'b0;
      r_bar_cnt <= '0;
      r_bar_idx <= '0;
      r_red     <= '0;
      r_grn     <= '0;
      r_blu     <= '0;
    end else begin
      r_hcount  <= w_hcount_next;
      r_vcount  <= w_vcount_next;
      r_frame   <= w_frame_next;
      r_mode    <= w_mode_next;
      r_overrun <= w_overrun_next;
      r_bar_cnt <= w_bar_cnt_next;
      r_bar_idx <= w_bar_idx_next;
      r_red     <= w_red;
      r_grn     <= w_grn;
      r_blu     <= w_blu;
    end
  end

  assign o_red     = r_red;
  assign o_grn     = r_grn;
  assign o_blu     = r_blu;
  assign o_hcount  = r_hcount;
  assign o_vcount  = r_vcount;
  assign o_frame   = r_frame;
  assign o_mode    = r_mode;
  assign o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_pattern_gen.sv
`default_nettype none
// ==========================================================================
// tb_pattern_gen : scoreboard bench with a frame-level reference model
// Rev 1.0
// ==========================================================================
module tb_pattern_gen;

  localparam int H   = 640;
  localparam int V   = 480;
  localparam int BOX = 32;

  logic        i_pixclk = 1'b0;
  logic        reset    = 1'b1;
  logic [2:0]  i_mode   = 3'd0;
  logic        i_rd     = 1'b0;
  logic        i_newline  = 1'b0;
  logic        i_newframe = 1'b0;
  logic [7:0]  o_red, o_grn, o_blu;
  logic [11:0] o_hcount, o_vcount;
  logic [7:0]  o_frame;
  logic [2:0]  o_mode;
  logic        o_overrun;

  pattern_gen #(
    .H_ACTIVE(H), .V_ACTIVE(V), .CW(12), .COLOR_W(8), .CHECK_LOG2(5), .BOX_SIZE(BOX)
  ) dut (
    .i_pixclk(i_pixclk), .reset(reset), .i_mode(i_mode), .i_rd(i_rd),
    .i_newline(i_newline), .i_newframe(i_newframe),
    .o_red(o_red), .o_grn(o_grn), .o_blu(o_blu),
    .o_hcount(o_hcount), .o_vcount(o_vcount), .o_frame(o_frame),
    .o_mode(o_mode), .o_overrun(o_overrun)
  );

  always #5 i_pixclk = ~i_pixclk;

  typedef struct {
    int rgb; int h; int v; int frame; int mode; int ovr;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: position, frame, latched mode and box kinematics.
  int m_h, m_v, m_frame, m_mode, m_ovr, m_bx, m_by, m_dx, m_dy;
  int bar_color[8] = '{32'hFFFFFF, 32'hFFFF00, 32'h00FFFF, 32'h00FF00,
                       32'hFF00FF, 32'hFF0000, 32'h0000FF, 32'h000000};

  function automatic int model_pixel();
    if (m_h >= H || m_v >= V) return 0;
    case (m_mode)
      0: return bar_color[m_h / (H / 8)];
      1: return ((((m_h / 32) + (m_v / 32)) % 2) == 1) ? 32'hFFFFFF : 0;
      2: return ((m_h % 256) << 16) | ((m_v % 256) << 8) | m_frame;
      3: return (m_h >= m_bx && m_h < m_bx + BOX && m_v >= m_by && m_v < m_by + BOX)
                ? 32'h00FF00 : 32'h000040;
      4: return (((m_frame / 32) % 2) == 1) ? 32'hFFFFFF : 0;
      default: return 0;
    endcase
  endfunction

  task automatic bounce(inout int pos, inout int dir, input int span);
    if (pos + dir < 0 || pos + dir + BOX > span) begin
      dir = -dir;
      pos = pos + dir;
    end else begin
      pos = pos + dir;
    end
  endtask

  task automatic model_step(input bit rst, input bit rd, input bit nl, input bit nf,
                            input int mode_in);
    exp_t e;
    if (rst) begin
      m_h = 0; m_v = 0; m_frame = 0; m_mode = 0; m_ovr = 0;
      m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1;
      e.rgb = 0;
    end else begin
      if (nl) begin
        m_h = 0;
        if (m_v < V) m_v = m_v + 1;
      end else if (rd) begin
        if (m_h == H) m_ovr = 1;
        else m_h = m_h + 1;
      end
      if (nf) begin
        m_v = 0;
        m_frame = (m_frame + 1) % 256;
        m_mode = mode_in;
        bounce(m_bx, m_dx, H);
        bounce(m_by, m_dy, V);
      end
      e.rgb = model_pixel();
    end
    e.h = m_h; e.v = m_v; e.frame = m_frame; e.mode = m_mode; e.ovr = m_ovr;
    q.push_back(e);
  endtask

  task automatic cyc(input bit rd, input bit nl, input bit nf);
    i_rd = rd; i_newline = nl; i_newframe = nf;
    @(posedge i_pixclk);
    model_step(reset, rd, nl, nf, int'(i_mode));
    #1;
  endtask

  task automatic run_rd(input int n);
    repeat (n) cyc(1'b1, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected entry per clock, compared half a cycle later.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_pixclk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rgb",     {8'd0, o_red, o_grn, o_blu}, e.rgb);
        chk("hcount",  {20'd0, o_hcount}, e.h);
        chk("vcount",  {20'd0, o_vcount}, e.v);
        chk("frame",   {24'd0, o_frame},  e.frame);
        chk("mode",    {29'd0, o_mode},   e.mode);
        chk("overrun", {31'd0, o_overrun}, e.ovr);
      end
    end
  end

  initial begin
    reset = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);

    // Colour bars across a full line, then overrun and newline-over-rd priority.
    i_mode = 3'd0;
    cyc(1'b0, 1'b1, 1'b0);
    run_rd(H);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    run_rd(5);

    // Mode request only takes effect at the frame boundary.
    i_mode = 3'd1;
    repeat (5) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    run_rd(32);
    repeat (32) cyc(1'b0, 1'b1, 1'b0);
    run_rd(70);

    reset = 1'b1;
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // Bouncing box: drive past the right wall, then visit the box edge.
    i_mode = 3'd3;
    repeat (609) cyc(1'b0, 1'b0, 1'b1);
    repeat (m_by) cyc(1'b0, 1'b1, 1'b0);
    run_rd(m_bx - 1);
    run_rd(3);
    repeat (700) cyc(1'b0, 1'b0, 1'b1);
    repeat (m_by + 5) cyc(1'b0, 1'b1, 1'b0);
    run_rd(m_bx + BOX + 4);

    // Gradient with the frame counter wrapping.
    i_mode = 3'd2;
    while (m_frame != 255) cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    repeat (10) cyc(1'b0, 1'b1, 1'b0);
    run_rd(303);

    // Vertical saturation.
    repeat (490) cyc(1'b0, 1'b1, 1'b0);
    run_rd(4);

    // Frame flash over enough frames to toggle frame[5].
    i_mode = 3'd4;
    cyc(1'b0, 1'b0, 1'b1);
    repeat (70) begin
      cyc(1'b0, 1'b1, 1'b1);
      run_rd(2);
    end

    // Randomized traffic: long lines first (overruns), then dense strobes.
    repeat (3000) begin
      if ($urandom % 64 == 0) i_mode = 3'($urandom % 8);
      cyc(($urandom % 4) != 0, ($urandom % 700) == 0, ($urandom % 1500) == 0);
    end
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    repeat (4000) begin
      if ($urandom % 32 == 0) i_mode = 3'($urandom % 8);
      cyc(($urandom % 3) != 0, ($urandom % 8) == 0, ($urandom % 300) == 0);
    end

    reset = 1'b1;
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    i_rd = 1'b0; i_newline = 1'b0; i_newframe = 1'b0;

    repeat (3) @(posedge i_pixclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
